// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: six single-cycle ops plus
// iterative unsigned shift-add multiply and restoring divide.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  // Single-cycle result, taken straight from the live inputs at acceptance
  always_comb begin
    shamt  = B[SHW-1:0];
    sc_res = '0;
    case (ALUOp)
      OP_ADD:  sc_res = A + B;
      OP_SUB:  sc_res = A - B;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = WIDTH'($unsigned($signed(A) >>> shamt));
      default: sc_res = '0;
    endcase
  end

  // One multiply step: acc_lo holds the remaining multiplier bits (LSB first)
  // and gradually fills with low product bits shifted in from acc_hi.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // One restoring-division step: acc_hi is the partial remainder, acc_lo
  // shifts the dividend out MSB first and the quotient in LSB first.
  always_comb begin
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    div_ge   = ~div_diff[WIDTH];
    div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      C        <= '0;
      C_hi     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (ALUOp)
              OP_MULU: begin
                state  <= MUL;
                busy   <= 1'b1;
                cnt    <= SHW'(WIDTH - 1);
                acc_hi <= '0;
                acc_lo <= A;
                opb    <= B;
              end
              OP_DIVU: begin
                if (B == '0) begin
                  C        <= '1;
                  C_hi     <= A;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  state  <= DIV;
                  busy   <= 1'b1;
                  cnt    <= SHW'(WIDTH - 1);
                  acc_hi <= '0;
                  acc_lo <= A;
                  opb    <= B;
                end
              end
              default: begin
                C        <= sc_res;
                C_hi     <= '0;
                div_zero <= 1'b0;
                done     <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b0;
            C        <= mul_lo_n;
            C_hi     <= mul_hi_n;
          end else begin
            cnt    <= cnt - 1'b1;
            acc_hi <= mul_hi_n;
            acc_lo <= mul_lo_n;
          end
        end
        DIV: begin
          if (cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b0;
            C        <= div_lo_n;
            C_hi     <= div_hi_n;
          end else begin
            cnt    <= cnt - 1'b1;
            acc_hi <= div_hi_n;
            acc_lo <= div_lo_n;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the single-cycle ALU. Takes operands A/B and a 3-bit ALUOp under a start/done handshake. Adds iterative unsigned multiply and divide alongside the six single-cycle operations. Sits between the register-file read ports and the writeback mux; the datapath controller stalls on `busy`.

## Interface

- WIDTH, 32: operand/result width; must be a power of two, at least 4
- SHW, $clog2(WIDTH): derived shift-amount width; not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (shift amount for shifts: B[SHW-1:0])
- ALUOp  in  3  000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra, 110 mulu, 111 divu
- C  out  WIDTH  result (product low / quotient for 110/111)
- C_hi  out  WIDTH  product high / remainder; 0 for ops 000-101
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: C/C_hi/div_zero valid
- div_zero  out  1  last divu had B=0; valid with done, held until next done

## Operation

- Three states:
  - IDLE: waits for start.
  - MUL and DIV: WIDTH iterations each, tracked by a down-counter.
- A, B and ALUOp are captured at acceptance; input changes after that have no effect.
- Single-cycle ops are computed from the inputs at acceptance and registered directly into C; the FSM stays in IDLE.
- Add and sub are modulo 2^WIDTH; no carry or overflow output.
- Shifts use only B[SHW-1:0]:
  - srl: zero fill.
  - sra: replicates A[WIDTH-1].
- mulu:
  - Unsigned shift-add, one multiplier bit per cycle, LSB first.
  - Result is the 2*WIDTH-bit product, split {C_hi, C}.
- divu:
  - Unsigned restoring division, one quotient bit per cycle, MSB first.
  - C = quotient, C_hi = remainder.
- divu with B=0:
  - Treated as single-cycle; no DIV state.
  - C = all ones, C_hi = A, div_zero=1.
- div_zero is cleared on every other done.
- C, C_hi and div_zero hold their values between done pulses. Iteration uses internal registers only, so outputs never show partial results.
- start while busy=1 is ignored and not queued.

## Timing

- Reset, asynchronous and immediate:
  - C=0, C_hi=0, busy=0, done=0, div_zero=0.
  - State IDLE, counter 0.
  - Asserting rst_n low mid-iteration aborts the operation; no done is produced.
- Acceptance: rising edge E0 with start=1 and busy=0.
- Single-cycle ops (and divu with B=0):
  - Results are updated at E0.
  - done=1 for the cycle after E0; busy stays 0.
- mulu / divu (B≠0):
  - busy=1 from E0 through edge E0+WIDTH-1.
  - At edge E0+WIDTH: results are updated, done=1 for one cycle, busy=0.
  - Latency is WIDTH cycles.
- Back-to-back: start may be high in the same cycle done=1. It is accepted (busy=0), giving one result per cycle for single-cycle ops.
- done is never high for two consecutive cycles unless two operations were accepted on consecutive edges.

## Test plan

- Basic ops, WIDTH=32, A=2, B=1, ops 000-101 issued back-to-back:
  - C = 3, 1, 0, 3, 1, 1.
  - done high each following cycle; C_hi=0.
- Boundaries:
  - A=1, B=2 sub -> C=0xFFFFFFFF.
  - A=0x80000000, B=0x24 srl -> 0x08000000 (only B[4:0]=4 used).
  - Same operands, sra -> 0xF8000000.
- mulu A=0xFFFFFFFF, B=2:
  - busy high 32 cycles.
  - done at E0+32 with C=0xFFFFFFFE, C_hi=1.
  - start pulses during busy are ignored; C is unchanged until done.
- divu:
  - A=100, B=7 -> C=14, C_hi=2, div_zero=0 after 32 cycles.
  - A=5, B=0 -> next-cycle done, C=0xFFFFFFFF, C_hi=5, div_zero=1.
  - A following add clears div_zero.
- Reset mid-op:
  - Assert rst_n=0 at cycle 10 of a mulu.
  - All outputs go to 0 immediately; no done appears.
  - After release, a new add is accepted normally.
- WIDTH=8 instance:
  - mulu 0xFF*0xFF -> C_hi=0xFE, C=0x01 after 8 cycles.
  - srl uses B[2:0].
